// File: rtl/riscv_register_bank.sv
// 32-entry RISC-V integer register file: two combinational read ports, one
// synchronous write port, x0 hardwired to zero, asynchronous active-low clear.
module riscv_register_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] Add_A,
  input  logic [ADDR_W-1:0] Add_B,
  input  logic [ADDR_W-1:0] Add_Dest,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Write_En,
  output logic [DATA_W-1:0] Info_A,
  output logic [DATA_W-1:0] Info_B
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  // x0 has no storage; only x1..x(NumRegs-1) are real flops.
  logic [DATA_W-1:0] regs_q [1:NumRegs-1];

  for (genvar g = 1; g < NumRegs; g++) begin : g_reg
    logic wr_en;

    // An X on Write_En evaluates false in the if below, so it never writes.
    assign wr_en = Write_En && (Add_Dest == ADDR_W'(g));

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        regs_q[g] <= '0;
      end else if (wr_en) begin
        regs_q[g] <= Write_Data;
      end
    end
  end

  // No write-to-read bypass: a same-cycle read of Add_Dest sees the old value.
  always_comb begin
    Info_A = '0;
    Info_B = '0;
    if (RST) begin
      if (Add_A != '0) Info_A = regs_q[Add_A];
      if (Add_B != '0) Info_B = regs_q[Add_B];
    end
  end

endmodule

// File: tb/tb_riscv_register_bank.sv
// Self-checking bench for riscv_register_bank: directed scenarios, a read-vector
// table and a randomized phase against an array-based reference model.
module tb_riscv_register_bank;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              CLK;
  logic              RST;
  logic [ADDR_W-1:0] Add_A;
  logic [ADDR_W-1:0] Add_B;
  logic [ADDR_W-1:0] Add_Dest;
  logic [DATA_W-1:0] Write_Data;
  logic              Write_En;
  logic [DATA_W-1:0] Info_A;
  logic [DATA_W-1:0] Info_B;

  riscv_register_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Add_A     (Add_A),
    .Add_B     (Add_B),
    .Add_Dest  (Add_Dest),
    .Write_Data(Write_Data),
    .Write_En  (Write_En),
    .Info_A    (Info_A),
    .Info_B    (Info_B)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] b;
    logic [DATA_W-1:0] ea;
    logic [DATA_W-1:0] eb;
  } rd_vec_t;

  rd_vec_t           tbl [6];
  logic [DATA_W-1:0] model [32];
  int                n_vec;
  int                n_err;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model update: architectural register file semantics.
  task automatic model_write(input logic we, input logic [ADDR_W-1:0] rd,
                             input logic [DATA_W-1:0] d);
    if (we && rd != 0) model[rd] = d;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Called 1 time unit after a rising edge; performs one clocked write.
  task automatic do_write(input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] d);
    Write_En   = 1'b1;
    Add_Dest   = rd;
    Write_Data = d;
    @(posedge CLK);
    model_write(1'b1, rd, d);
    #1;
    Write_En = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    RST        = 1'b1;
    Add_A      = '0;
    Add_B      = '0;
    Add_Dest   = '0;
    Write_Data = '0;
    Write_En   = 1'b0;
    model_clear();

    // 1: reset, then repeated writes to x0
    #2 RST = 1'b0;
    #1;
    check("reset_info_a", Info_A, '0);
    check("reset_info_b", Info_B, '0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    Write_En   = 1'b1;
    Add_Dest   = '0;
    Write_Data = 32'd30;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      check("x0_write_a", Info_A, '0);
      check("x0_write_b", Info_B, '0);
    end
    Write_En = 1'b0;

    // 2: sequential writes, then table of read pairs
    do_write(5'd1, 32'd20);
    idle(9);
    do_write(5'd2, 32'd25);
    idle(9);
    do_write(5'd3, 32'd5);
    idle(9);
    do_write(5'd4, 32'd8);
    idle(9);
    tbl[0] = '{a: 5'd3, b: 5'd1, ea: 32'd5,  eb: 32'd20};
    tbl[1] = '{a: 5'd2, b: 5'd0, ea: 32'd25, eb: 32'd0};
    tbl[2] = '{a: 5'd4, b: 5'd4, ea: 32'd8,  eb: 32'd8};
    tbl[3] = '{a: 5'd1, b: 5'd2, ea: 32'd20, eb: 32'd25};
    tbl[4] = '{a: 5'd0, b: 5'd3, ea: 32'd0,  eb: 32'd5};
    tbl[5] = '{a: 5'd5, b: 5'd31, ea: 32'd0, eb: 32'd0};
    for (int i = 0; i < 6; i++) begin
      Add_A = tbl[i].a;
      Add_B = tbl[i].b;
      #1;
      check($sformatf("tbl%0d_a", i), Info_A, tbl[i].ea);
      check($sformatf("tbl%0d_b", i), Info_B, tbl[i].eb);
    end

    // 3: write disabled for many edges
    Write_En   = 1'b0;
    Add_Dest   = 5'd4;
    Write_Data = 32'd99;
    idle(10);
    Add_A = 5'd4;
    #1;
    check("we_off_x4", Info_A, 32'd8);

    // 4: both ports on one register, same-cycle write has no bypass
    Add_A      = 5'd3;
    Add_B      = 5'd3;
    Write_En   = 1'b1;
    Add_Dest   = 5'd7;
    Write_Data = 32'd4;
    #1;
    check("same_reg_a", Info_A, 32'd5);
    check("same_reg_b", Info_B, 32'd5);
    Add_A = 5'd7;
    #1;
    check("pre_edge_x7", Info_A, 32'd0);
    @(posedge CLK);
    model_write(1'b1, 5'd7, 32'd4);
    #1;
    Write_En = 1'b0;
    check("post_edge_x7", Info_A, 32'd4);

    // 5: asynchronous reset between edges; writes blocked while held
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("async_rst_a", Info_A, '0);
    check("async_rst_b", Info_B, '0);
    Write_En   = 1'b1;
    Add_Dest   = 5'd9;
    Write_Data = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    Write_En = 1'b0;
    model_clear();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      Add_A = 5'(i);
      Add_B = 5'(31 - i);
      #1;
      check($sformatf("post_rst_x%0d", i), Info_A, '0);
      check($sformatf("post_rst_x%0d", 31 - i), Info_B, '0);
    end
    @(posedge CLK);
    #1;

    // 6: full-width values and top address, neighbours untouched
    do_write(5'd30, 32'h1234_5678);
    do_write(5'd15, 32'hA5A5_5A5A);
    do_write(5'd31, 32'hFFFF_FFFF);
    do_write(5'd16, 32'h8000_0001);
    Add_A = 5'd31;
    Add_B = 5'd16;
    #1;
    check("x31_full", Info_A, 32'hFFFF_FFFF);
    check("x16_bits", Info_B, 32'h8000_0001);
    Add_A = 5'd30;
    Add_B = 5'd15;
    #1;
    check("x30_kept", Info_A, 32'h1234_5678);
    check("x15_kept", Info_B, 32'hA5A5_5A5A);

    // Randomized traffic: reads checked before each edge against the model
    for (int i = 0; i < 400; i++) begin
      logic              we;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] d;
      we         = ($urandom_range(0, 3) != 0);
      rd         = 5'($urandom_range(0, 31));
      d          = $urandom;
      Write_En   = we;
      Add_Dest   = rd;
      Write_Data = d;
      Add_A      = 5'($urandom_range(0, 31));
      Add_B      = ($urandom_range(0, 4) == 0) ? rd : 5'($urandom_range(0, 31));
      #1;
      check("rand_a", Info_A, model[Add_A]);
      check("rand_b", Info_B, model[Add_B]);
      if (i % 97 == 50) begin
        @(negedge CLK);
        RST = 1'b0;
        #1;
        model_clear();
        check("rand_rst_a", Info_A, '0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
      end else begin
        @(posedge CLK);
        model_write(we, rd, d);
        #1;
      end
    end
    Write_En = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
